// File: rtl/frame_serializer_nch_pkg.sv
// Shared types and helpers for the N-channel frame serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_serializer_nch_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Widest channel word the field extractor can handle.
    localparam int MAX_WIDTH = 64;

    // Bit counter width for a given transmitted bit count, never below 1.
    function automatic int cnt_width(input int out_bits);
        return (out_bits <= 2) ? 1 : $clog2(out_bits);
    endfunction

    // Right-align the top out_bits bits of a width-bit channel word; the caller
    // keeps the low out_bits bits of the result, so the truncated LSBs drop away.
    function automatic logic [MAX_WIDTH-1:0] extract_field(
        input logic [MAX_WIDTH-1:0] word,
        input int                   width,
        input int                   out_bits
    );
        return word >> (width - out_bits);
    endfunction

endpackage

// File: rtl/frame_serializer_nch_lane.sv
// One serializer lane: holding register, shift register and bit-order select.
// Latency: output bit is a register bit, valid the cycle after transfer.
// Backpressure: none; obeys load/transfer/shift strobes from the shared FSM.
module serializer_lane
    import frame_serializer_nch_pkg::*;
#(
    parameter int WIDTH     = 40,
    parameter int OUT_BITS  = 40,
    parameter int LSB_FIRST = 0
) (
    input  logic             i_sclk,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_xfer,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_word,
    output logic             o_bit
);

    logic [OUT_BITS-1:0] r_hold;
    logic [OUT_BITS-1:0] r_shift;
    logic [OUT_BITS-1:0] w_field;

    assign w_field = OUT_BITS'(extract_field(MAX_WIDTH'(i_word), WIDTH, OUT_BITS));

    // Holding register captures the kept field of an accepted load.
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hold <= '0;
        end else if (i_clear) begin
            r_hold <= '0;
        end else if (i_load) begin
            r_hold <= w_field;
        end
    end

    // Shift register: transfer wins over shifting; zero fill empties it by word end.
    always_ff @(posedge i_sclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_shift <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
        end else if (i_xfer) begin
            r_shift <= r_hold;
        end else if (i_shift) begin
            r_shift <= (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);
        end
    end

    assign o_bit = (LSB_FIRST != 0) ? r_shift[0] : r_shift[OUT_BITS-1];

endmodule

// File: rtl/frame_serializer_nch.sv
// N-channel lock-step parallel-to-serial output stage with error flags.
// Latency: first serial bit and OutReady one Sclk after Frame is sampled.
// Backpressure: load_ready low while hold is full; extra loads set overrun.
module frame_serializer_nch
    import frame_serializer_nch_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int WIDTH     = 40,
    parameter int OUT_BITS  = 40,
    parameter int LSB_FIRST = 0
) (
    input  logic                 Sclk,
    input  logic                 Reset_n,
    input  logic                 Clear,
    input  logic                 Frame,
    input  logic                 load,
    input  logic [NCH*WIDTH-1:0] data_in,
    output logic                 load_ready,
    output logic [NCH-1:0]       OutputSerial,
    output logic                 OutReady,
    output logic                 overrun,
    output logic                 underrun,
    output logic                 frame_err
);

    localparam int CNT_W = cnt_width(OUT_BITS);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hold_full;
    logic             r_out_ready;
    logic             r_overrun;
    logic             r_underrun;
    logic             r_frame_err;

    logic w_frame_ok;
    logic w_xfer;
    logic w_load_acc;
    logic w_shift;

    // A Frame is honoured when idle or on the last bit (back-to-back words).
    assign w_frame_ok = Frame && ((r_state == IDLE) || (r_cnt == '0));
    assign w_xfer     = w_frame_ok && r_hold_full;
    // A load is accepted into an empty hold or one being consumed this cycle.
    assign w_load_acc = load && (!r_hold_full || w_xfer);
    assign w_shift    = (r_state == SHIFT);

    // Shared FSM and bit counter; OutReady registered alongside the state.
    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_ready <= 1'b0;
        end else if (Clear) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_ready <= 1'b0;
        end else if (w_xfer) begin
            r_state     <= SHIFT;
            r_cnt       <= CNT_W'(OUT_BITS - 1);
            r_out_ready <= 1'b1;
        end else if (r_state == SHIFT) begin
            if (r_cnt == '0) begin
                r_state     <= IDLE;
                r_out_ready <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Hold occupancy: an accepted load refills even when the hold is transferred.
    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hold_full <= 1'b0;
        end else if (Clear) begin
            r_hold_full <= 1'b0;
        end else if (w_load_acc) begin
            r_hold_full <= 1'b1;
        end else if (w_xfer) begin
            r_hold_full <= 1'b0;
        end
    end

    // Sticky error flags, cleared only by reset or Clear.
    always_ff @(posedge Sclk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_overrun   <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (Clear) begin
            r_overrun   <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (load && !w_load_acc)       r_overrun   <= 1'b1;
            if (w_frame_ok && !r_hold_full) r_underrun  <= 1'b1;
            if (Frame && !w_frame_ok)      r_frame_err <= 1'b1;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        serializer_lane #(
            .WIDTH    (WIDTH),
            .OUT_BITS (OUT_BITS),
            .LSB_FIRST(LSB_FIRST)
        ) u_lane (
            .i_sclk   (Sclk),
            .i_reset_n(Reset_n),
            .i_clear  (Clear),
            .i_load   (w_load_acc),
            .i_xfer   (w_xfer),
            .i_shift  (w_shift),
            .i_word   (data_in[k*WIDTH +: WIDTH]),
            .o_bit    (OutputSerial[k])
        );
    end

    assign load_ready = !r_hold_full;
    assign OutReady   = r_out_ready;
    assign overrun    = r_overrun;
    assign underrun   = r_underrun;
    assign frame_err  = r_frame_err;

endmodule
